cdb_broadcaster: RTL and testbench

//  Transmit end of the CDB: collects completed results from NUM_FU functional units and drives
//  CDB_0/CDB_1, which the PRF writes and marks ready (and RS/ROB snoop) each cycle.

---
 rtl/cdb_broadcaster_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 33 +++
 rtl/cdb_broadcaster.sv | 112 +++++++++++
 tb/tb_cdb_broadcaster.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB result types and widths used by the broadcaster and its FU/PRF/RS/ROB neighbours.
package cdb_broadcaster_pkg;
    localparam int PR_SIZE = 64;
    localparam int PR_BITS = $clog2(PR_SIZE);
    localparam int XLEN    = 32;

    typedef struct packed {
        logic               valid;
        logic [PR_BITS-1:0] PRN;
        logic [XLEN-1:0]    FU_result;
    } CDB;

    typedef struct packed {
        logic               valid;
        logic               thread_id;
        logic [PR_BITS-1:0] PRN;
        logic [XLEN-1:0]    FU_result;
    } FU_RESULT;

    function automatic logic thread_killed(input logic tid, input logic mp0, input logic mp1);
        return tid ? mp1 : mp0;
    endfunction
endpackage

// File: rtl/rr_pick2.sv
// Two-grant rotating-priority picker: first and second requester found scanning from ptr upward.
module rr_pick2 #(
    parameter int NUM_FU = 4,
    parameter int PTR_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  gnt0_idx,
    output logic              gnt0_v,
    output logic [PTR_W-1:0]  gnt1_idx,
    output logic              gnt1_v
);
    always_comb begin
        int pos;
        gnt0_idx = '0;
        gnt0_v   = 1'b0;
        gnt1_idx = '0;
        gnt1_v   = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_FU) pos = pos - NUM_FU;
            if (req[pos[PTR_W-1:0]]) begin
                if (!gnt0_v) begin
                    gnt0_v   = 1'b1;
                    gnt0_idx = pos[PTR_W-1:0];
                end else if (!gnt1_v) begin
                    gnt1_v   = 1'b1;
                    gnt1_idx = pos[PTR_W-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: one hold slot per FU, two-wide round-robin grant, thread squash, registered CDB.
// Build option CDB_BYPASS_EN lets an incoming result into an empty slot compete in the same cycle.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int NUM_FU = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mispredict_thread_0,
    input  logic                  mispredict_thread_1,
    input  FU_RESULT [NUM_FU-1:0] fu_in,
    output logic [NUM_FU-1:0]     fu_ready,
    output CDB                    CDB_0,
    output CDB                    CDB_1,
    output logic                  CDB_thread_0,
    output logic                  CDB_thread_1
);
    localparam int PTR_W = $clog2(NUM_FU);

    FU_RESULT [NUM_FU-1:0] hold;
    logic [NUM_FU-1:0]     hold_valid, squash, in_kill, in_valid, byp, req, grant, accept;
    logic [PR_BITS-1:0]    cand_prn [NUM_FU];
    logic [XLEN-1:0]       cand_res [NUM_FU];
    logic [NUM_FU-1:0]     cand_th;
    logic [PTR_W-1:0]      rr_ptr, gnt0_idx, gnt1_idx;
    logic                  gnt0_v, gnt1_v;

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return (int'(idx) == NUM_FU - 1) ? PTR_W'(0) : idx + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            hold_valid[i] = hold[i].valid;
            in_valid[i]   = fu_in[i].valid;
            squash[i]     = hold[i].valid &
                            thread_killed(hold[i].thread_id, mispredict_thread_0, mispredict_thread_1);
            in_kill[i]    = fu_in[i].valid &
                            thread_killed(fu_in[i].thread_id, mispredict_thread_0, mispredict_thread_1);
`ifdef CDB_BYPASS_EN
            byp[i]        = ~hold[i].valid & fu_in[i].valid & ~in_kill[i];
`else
            byp[i]        = 1'b0;
`endif
            req[i]        = (hold[i].valid & ~squash[i]) | byp[i];
            // A non-empty slot always wins its position; the input only competes when the slot is empty.
            cand_prn[i]   = hold[i].valid ? hold[i].PRN       : fu_in[i].PRN;
            cand_res[i]   = hold[i].valid ? hold[i].FU_result : fu_in[i].FU_result;
            cand_th[i]    = hold[i].valid ? hold[i].thread_id : fu_in[i].thread_id;
        end
    end

    rr_pick2 #(
        .NUM_FU (NUM_FU),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req      (req),
        .ptr      (rr_ptr),
        .gnt0_idx (gnt0_idx),
        .gnt0_v   (gnt0_v),
        .gnt1_idx (gnt1_idx),
        .gnt1_v   (gnt1_v)
    );

    always_comb begin
        grant = '0;
        if (gnt0_v) grant[gnt0_idx] = 1'b1;
        if (gnt1_v) grant[gnt1_idx] = 1'b1;
    end

    assign fu_ready = ~hold_valid | grant | squash;
    // A bypassed result that wins a grant goes straight to the CDB and never occupies the slot.
    assign accept   = in_valid & fu_ready & ~in_kill & ~(byp & grant);

    always_ff @(posedge clock) begin
        if (reset) begin
            hold         <= '0;
            rr_ptr       <= '0;
            CDB_0        <= '0;
            CDB_1        <= '0;
            CDB_thread_0 <= 1'b0;
            CDB_thread_1 <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i])               hold[i]       <= fu_in[i];
                else if (grant[i] | squash[i]) hold[i].valid <= 1'b0;
            end

            CDB_0        <= '0;
            CDB_thread_0 <= 1'b0;
            if (gnt0_v) begin
                CDB_0.valid     <= 1'b1;
                CDB_0.PRN       <= cand_prn[gnt0_idx];
                CDB_0.FU_result <= cand_res[gnt0_idx];
                CDB_thread_0    <= cand_th[gnt0_idx];
            end

            CDB_1        <= '0;
            CDB_thread_1 <= 1'b0;
            if (gnt1_v) begin
                CDB_1.valid     <= 1'b1;
                CDB_1.PRN       <= cand_prn[gnt1_idx];
                CDB_1.FU_result <= cand_res[gnt1_idx];
                CDB_thread_1    <= cand_th[gnt1_idx];
            end

            if (gnt1_v)      rr_ptr <= ptr_after(gnt1_idx);
            else if (gnt0_v) rr_ptr <= ptr_after(gnt0_idx);
        end
    end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: FU model honours fu_ready, results matched as they hit the CDB.
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    localparam int NUM_FU = 4;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
    localparam logic [1:0] OVS_RDY = 2'b11;
`else
    localparam int LAT = 2;
    localparam logic [1:0] OVS_RDY = 2'b00;
`endif

    logic                  clock, reset, mispredict_thread_0, mispredict_thread_1;
    FU_RESULT [NUM_FU-1:0] fu_in;
    logic [NUM_FU-1:0]     fu_ready;
    CDB                    CDB_0, CDB_1;
    logic                  CDB_thread_0, CDB_thread_1;

    cdb_broadcaster #(.NUM_FU(NUM_FU)) dut (
        .clock               (clock),
        .reset               (reset),
        .mispredict_thread_0 (mispredict_thread_0),
        .mispredict_thread_1 (mispredict_thread_1),
        .fu_in               (fu_in),
        .fu_ready            (fu_ready),
        .CDB_0               (CDB_0),
        .CDB_1               (CDB_1),
        .CDB_thread_0        (CDB_thread_0),
        .CDB_thread_1        (CDB_thread_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [PR_BITS-1:0] prn;
        logic [XLEN-1:0]    res;
        logic               th;
        int                 t;
    } exp_t;

    FU_RESULT          pend [NUM_FU][$];
    exp_t              exp_q [$];
    logic [NUM_FU-1:0] rdy_log [$];
    bit                seen [PR_SIZE];
    int                seen_cnt, nstep, total, bad, uid, base;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic FU_RESULT mk(input logic th, input int prn, input int res);
        FU_RESULT r;
        r.valid     = 1'b1;
        r.thread_id = th;
        r.PRN       = prn[PR_BITS-1:0];
        r.FU_result = res[XLEN-1:0];
        return r;
    endfunction

    task automatic take(input CDB c, input logic th, input string tag);
        int k;
        int lat;
        k = -1;
        foreach (exp_q[j])
            if (k < 0 && exp_q[j].prn == c.PRN && exp_q[j].res == c.FU_result && exp_q[j].th == th) k = j;
        chk({tag, "_known"}, 64'(k >= 0), 64'd1);
        seen[c.PRN] = 1'b1;
        seen_cnt++;
        if (k >= 0) begin
            lat = nstep - exp_q[k].t;
            chk({tag, "_latency"}, 64'(lat >= LAT && lat <= LAT + 1), 64'd1);
            exp_q.delete(k);
        end
    endtask

    task automatic monitor();
        chk("c1_needs_c0", 64'(CDB_1.valid & ~CDB_0.valid), 64'd0);
        if (CDB_0.valid) take(CDB_0, CDB_thread_0, "cdb0");
        else chk("cdb0_idle_zero", 64'({CDB_0, CDB_thread_0}), 64'd0);
        if (CDB_1.valid) take(CDB_1, CDB_thread_1, "cdb1");
        else chk("cdb1_idle_zero", 64'({CDB_1, CDB_thread_1}), 64'd0);
    endtask

    // One clock: check what is on the bus, present FU heads, record what the FU model sees accepted.
    task automatic step(input logic m0 = 1'b0, input logic m1 = 1'b0);
        logic [NUM_FU-1:0] pop;
        logic sq;
        monitor();
        mispredict_thread_0 = m0;
        mispredict_thread_1 = m1;
        for (int i = 0; i < NUM_FU; i++) fu_in[i] = (pend[i].size() > 0) ? pend[i][0] : '0;
        #1;
        rdy_log.push_back(fu_ready);
        for (int j = exp_q.size() - 1; j >= 0; j--)
            if ((exp_q[j].th && m1) || (!exp_q[j].th && m0)) exp_q.delete(j);
        pop = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_in[i].valid) begin
                sq = fu_in[i].thread_id ? m1 : m0;
                if (fu_ready[i] && !sq)
                    exp_q.push_back('{prn: fu_in[i].PRN, res: fu_in[i].FU_result,
                                      th: fu_in[i].thread_id, t: nstep});
                pop[i] = fu_ready[i] | sq;
            end
        end
        @(posedge clock);
        for (int i = 0; i < NUM_FU; i++) if (pop[i]) void'(pend[i].pop_front());
        nstep++;
        @(negedge clock);
        mispredict_thread_0 = 1'b0;
        mispredict_thread_1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fu_in = '0;
        mispredict_thread_0 = 1'b0;
        mispredict_thread_1 = 1'b0;
        for (int i = 0; i < NUM_FU; i++) pend[i].delete();
        exp_q.delete();
        for (int p = 0; p < PR_SIZE; p++) seen[p] = 1'b0;
        seen_cnt = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag);
        int left;
        repeat (8) step();
        left = exp_q.size();
        for (int i = 0; i < NUM_FU; i++) left += pend[i].size();
        chk({tag, "_drained"}, 64'(left), 64'd0);
    endtask

    initial begin
        total = 0; bad = 0; nstep = 0; uid = 0;
        reset = 1'b1;
        fu_in = '0;
        mispredict_thread_0 = 1'b0;
        mispredict_thread_1 = 1'b0;
        @(negedge clock);

        // reset state
        do_reset();
        chk("rst_cdb0", 64'({CDB_0, CDB_thread_0}), 64'd0);
        chk("rst_cdb1", 64'({CDB_1, CDB_thread_1}), 64'd0);
        chk("rst_ready", 64'(fu_ready), 64'hf);

        // single result from FU2
        pend[2].push_back(mk(1'b0, 5, 55));
        for (int k = 0; k < LAT; k++) step();
        chk("single_c0", 64'({CDB_0.valid, CDB_0.PRN, CDB_0.FU_result}), {25'd0, 1'b1, 6'd5, 32'd55});
        chk("single_c1_v", 64'(CDB_1.valid), 64'd0);
        drain("single");

        // oversubscription: four results at once, each FU with a follow-up result
        do_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            pend[i].push_back(mk(1'b0, i + 1, 100 + i));
            pend[i].push_back(mk(1'b0, 11 + i, 110 + i));
        end
        base = rdy_log.size();
        for (int k = 0; k < LAT; k++) step();
        chk("ovs_pair0_c0", 64'({CDB_0.valid, CDB_0.PRN}), {57'd0, 1'b1, 6'd1});
        chk("ovs_pair0_c1", 64'({CDB_1.valid, CDB_1.PRN}), {57'd0, 1'b1, 6'd2});
        step();
        chk("ovs_pair1_c0", 64'({CDB_0.valid, CDB_0.PRN}), {57'd0, 1'b1, 6'd3});
        chk("ovs_pair1_c1", 64'({CDB_1.valid, CDB_1.PRN}), {57'd0, 1'b1, 6'd4});
        chk("ovs_ready23", 64'(rdy_log[base + 1][3:2]), 64'(OVS_RDY));
        drain("ovs");
        chk("ovs_count", 64'(seen_cnt), 64'd8);

        // fairness: FU0 and FU3 always busy, FU1/FU2 intermittent; includes PRN 0 and PR_SIZE-1
        for (int k = 0; k < 8; k++) begin
            pend[0].push_back(mk(k[0], 20 + k, 2000 + k));
            pend[3].push_back(mk(~k[0], 30 + k, 3000 + k));
        end
        pend[1].push_back(mk(1'b0, 0, 1000));
        pend[1].push_back(mk(1'b1, 40, 1001));
        pend[2].push_back(mk(1'b1, PR_SIZE - 1, 1002));
        pend[2].push_back(mk(1'b0, 41, 1003));
        repeat (12) step();
        drain("fair");
        chk("fair_prn0", 64'(seen[0]), 64'd1);
        chk("fair_prnmax", 64'(seen[PR_SIZE - 1]), 64'd1);

        // squash thread 1 while a t1 and a t0 result are held
        do_reset();
        pend[0].push_back(mk(1'b0, 20, 200));
        pend[1].push_back(mk(1'b0, 21, 201));
        pend[2].push_back(mk(1'b1, 46, 460));
        pend[3].push_back(mk(1'b0, 2, 22));
        pend[0].push_back(mk(1'b1, 48, 480));
        step();
        base = rdy_log.size();
        step(1'b0, 1'b1);
        chk("sq_ready2", 64'(rdy_log[base][2]), 64'd1);
        drain("sq");
        chk("sq_prn2_seen", 64'(seen[2]), 64'd1);
        chk("sq_prn46_absent", 64'(seen[46]), 64'd0);
        chk("sq_prn48_absent", 64'(seen[48]), 64'd0);

        // reset in the middle of a full burst
        do_reset();
        for (int i = 0; i < NUM_FU; i++) pend[i].push_back(mk(1'b0, 50 + i, 500 + i));
        step();
        do_reset();
        repeat (5) step();
        chk("rstmid_quiet", 64'(seen_cnt), 64'd0);
        chk("rstmid_ready", 64'(fu_ready), 64'hf);

        // random traffic with occasional mispredicts
        do_reset();
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                if (pend[i].size() < 2 && $urandom_range(0, 1) == 1) begin
                    pend[i].push_back(mk(1'($urandom_range(0, 1)), uid % PR_SIZE, 5000 + uid));
                    uid++;
                end
            step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
